// File: rtl/exhaustive_eval_ctrl.sv
// exhaustive_eval_ctrl
//   Sweeps every input vector 0..2^NUM_PI-1 onto a combinational CUT and its
//   golden model, counts mismatched output bits and records the first failing
//   vector. The count is the candidate fitness used by the evolution loop.
//   Optional feature macro: EVAL_EARLY_ABORT_EN (adds abort_thresh / aborted,
//   ending a run as soon as the running error count reaches the threshold).
module exhaustive_eval_ctrl #(
  parameter int NUM_PI      = 7,
  parameter int NUM_PO      = 2,
  parameter int CUT_LATENCY = 0,
  parameter int ERR_W       = NUM_PI + $clog2(NUM_PO + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [NUM_PI-1:0] vec_out,
  input  logic [NUM_PO-1:0] cut_po,
  input  logic [NUM_PO-1:0] ref_po,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [NUM_PI-1:0] first_err_vec
`ifdef EVAL_EARLY_ABORT_EN
  ,
  input  logic [ERR_W-1:0]  abort_thresh,
  output logic              aborted
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CMP    = 2'd2,
    FIN    = 2'd3
  } state_t;

  // Settle counter runs 0..CUT_LATENCY-1; clamp so a zero latency still elaborates.
  localparam int              WAIT_LAST_I = (CUT_LATENCY > 0) ? (CUT_LATENCY - 1) : 0;
  localparam logic [3:0]      WAIT_LAST   = WAIT_LAST_I[3:0];
  localparam bit              HAS_SETTLE  = (CUT_LATENCY > 0);
  localparam logic [NUM_PI-1:0] VEC_LAST  = {NUM_PI{1'b1}};
  localparam logic [NUM_PI-1:0] VEC_ONE   = {{(NUM_PI-1){1'b0}}, 1'b1};

  // Number of set bits in a CUT/golden difference word.
  function automatic logic [ERR_W-1:0] popcount(input logic [NUM_PO-1:0] d);
    logic [ERR_W-1:0] n;
    n = {ERR_W{1'b0}};
    for (int i = 0; i < NUM_PO; i++) begin
      n = n + {{(ERR_W-1){1'b0}}, d[i]};
    end
    return n;
  endfunction

  state_t              state_r, state_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic [NUM_PI-1:0]   vec_r, vec_nxt_s;
  logic [ERR_W-1:0]    err_r, err_nxt_s;
  logic                fev_r, fev_nxt_s;
  logic [NUM_PI-1:0]   fvec_r, fvec_nxt_s;
  logic [3:0]          wait_r, wait_nxt_s;
  logic [NUM_PO-1:0]   diff_s;
  logic [ERR_W-1:0]    err_sum_s;
  logic                abort_hit_s;
  logic                aborted_r, aborted_nxt_s;

  // Running error total including the vector currently being compared.
  always_comb begin
    diff_s    = cut_po ^ ref_po;
    err_sum_s = err_r + popcount(diff_s);
`ifdef EVAL_EARLY_ABORT_EN
    abort_hit_s = (abort_thresh != {ERR_W{1'b0}}) && (err_sum_s >= abort_thresh);
`else
    abort_hit_s = 1'b0;
`endif
  end

  // Next-state and next-datapath decode; everything holds unless a state acts.
  always_comb begin
    state_nxt_s   = state_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    vec_nxt_s     = vec_r;
    err_nxt_s     = err_r;
    fev_nxt_s     = fev_r;
    fvec_nxt_s    = fvec_r;
    wait_nxt_s    = wait_r;
    aborted_nxt_s = aborted_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          busy_nxt_s    = 1'b1;
          vec_nxt_s     = {NUM_PI{1'b0}};
          err_nxt_s     = {ERR_W{1'b0}};
          fev_nxt_s     = 1'b0;
          fvec_nxt_s    = {NUM_PI{1'b0}};
          wait_nxt_s    = 4'd0;
          aborted_nxt_s = 1'b0;
          if (HAS_SETTLE) begin
            state_nxt_s = SETTLE;
          end else begin
            state_nxt_s = CMP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (wait_r == WAIT_LAST) begin
          wait_nxt_s  = 4'd0;
          state_nxt_s = CMP;
        end else begin
          wait_nxt_s  = wait_r + 4'd1;
        end
      end
      CMP: begin
        err_nxt_s = err_sum_s;
        if ((diff_s != {NUM_PO{1'b0}}) && !fev_r) begin
          fev_nxt_s  = 1'b1;
          fvec_nxt_s = vec_r;
        end else begin
          fev_nxt_s  = fev_r;
        end
        if ((vec_r == VEC_LAST) || abort_hit_s) begin
          // Last vector (or abort): vec_out stays put so the final vector remains visible.
          state_nxt_s   = FIN;
          busy_nxt_s    = 1'b0;
          done_nxt_s    = 1'b1;
          aborted_nxt_s = abort_hit_s;
        end else begin
          vec_nxt_s  = vec_r + VEC_ONE;
          wait_nxt_s = 4'd0;
          if (HAS_SETTLE) begin
            state_nxt_s = SETTLE;
          end else begin
            state_nxt_s = CMP;
          end
        end
      end
      FIN: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs and run bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      vec_r     <= {NUM_PI{1'b0}};
      err_r     <= {ERR_W{1'b0}};
      fev_r     <= 1'b0;
      fvec_r    <= {NUM_PI{1'b0}};
      wait_r    <= 4'd0;
      aborted_r <= 1'b0;
    end else begin
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      vec_r     <= vec_nxt_s;
      err_r     <= err_nxt_s;
      fev_r     <= fev_nxt_s;
      fvec_r    <= fvec_nxt_s;
      wait_r    <= wait_nxt_s;
      aborted_r <= aborted_nxt_s;
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign vec_out         = vec_r;
  assign err_count       = err_r;
  assign first_err_valid = fev_r;
  assign first_err_vec   = fvec_r;
`ifdef EVAL_EARLY_ABORT_EN
  assign aborted         = aborted_r;
`endif

endmodule

// File: tb/tb_exhaustive_eval_ctrl.sv
// tb_exhaustive_eval_ctrl
//   Two DUT instances: CUT_LATENCY=0 (combinational CUT) and CUT_LATENCY=2
//   (CUT and golden model behind a 2-cycle delay). The CUT is the golden
//   table XOR a per-vector fault mask; the reference model sums the mask bits.
module tb_exhaustive_eval_ctrl;

  localparam int NV = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic       busy0, busy1, done0, done1, fev0, fev1;
  logic [6:0] vec0, vec1, fvec0, fvec1;
  logic [1:0] cut0, ref0, cut1, ref1;
  logic [8:0] err0, err1;
`ifdef EVAL_EARLY_ABORT_EN
  logic [8:0] thr0, thr1;
  logic       ab0, ab1;
`endif

  logic [1:0] ref_tab  [NV];
  logic [1:0] mask_tab [NV];
  logic [1:0] p1c, p2c, p1r, p2r;

  exhaustive_eval_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .vec_out(vec0), .cut_po(cut0), .ref_po(ref0), .err_count(err0),
    .first_err_valid(fev0), .first_err_vec(fvec0)
`ifdef EVAL_EARLY_ABORT_EN
    , .abort_thresh(thr0), .aborted(ab0)
`endif
  );

  exhaustive_eval_ctrl #(.CUT_LATENCY(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .vec_out(vec1), .cut_po(cut1), .ref_po(ref1), .err_count(err1),
    .first_err_valid(fev1), .first_err_vec(fvec1)
`ifdef EVAL_EARLY_ABORT_EN
    , .abort_thresh(thr1), .aborted(ab1)
`endif
  );

  // Combinational CUT/golden pair for the zero-latency instance.
  always_comb begin
    ref0 = ref_tab[vec0];
    cut0 = ref_tab[vec0] ^ mask_tab[vec0];
  end

  // Two-cycle delayed CUT/golden pair for the latency-2 instance.
  always @(posedge clk) begin
    p1c <= ref_tab[vec1] ^ mask_tab[vec1];
    p2c <= p1c;
    p1r <= ref_tab[vec1];
    p2r <= p1r;
  end
  assign cut1 = p2c;
  assign ref1 = p2r;

  typedef struct {int err; int fev; int fvec; int vec; int ab;} res_t;
  typedef struct {int mode; int err; int fev; int fvec;} vec_rec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int dn(input int inst);
    return (inst == 0) ? int'(done0) : int'(done1);
  endfunction

  function automatic int bsy(input int inst);
    return (inst == 0) ? int'(busy0) : int'(busy1);
  endfunction

  task automatic drive_start(input int inst, input logic v);
    if (inst == 0) start0 = v;
    else           start1 = v;
  endtask

  task automatic fill_ref();
    for (int v = 0; v < NV; v++) ref_tab[v] = 2'($urandom_range(0, 3));
  endtask

  task automatic fill_mask(input int mode);
    for (int v = 0; v < NV; v++) begin
      case (mode)
        0: mask_tab[v] = 2'b00;
        1: mask_tab[v] = 2'b01;
        2: mask_tab[v] = (v == 8'h55) ? 2'b11 : 2'b00;
        3: mask_tab[v] = (v >= 8'h10) ? 2'b10 : 2'b00;
        4: mask_tab[v] = (v == 127) ? 2'b11 : 2'b00;
        default: mask_tab[v] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      endcase
    end
  endtask

  // Reference model: walk the vector space, summing mismatched bits.
  task automatic model(input int thr, output res_t e);
    int bits;
    e.err = 0; e.fev = 0; e.fvec = 0; e.vec = NV - 1; e.ab = 0;
    for (int v = 0; v < NV; v++) begin
      bits = int'(mask_tab[v][0]) + int'(mask_tab[v][1]);
      e.err += bits;
      if (bits != 0 && e.fev == 0) begin
        e.fev = 1;
        e.fvec = v;
      end
      if (thr != 0 && e.err >= thr) begin
        e.vec = v;
        e.ab = 1;
        break;
      end
    end
  endtask

  task automatic kick(input int inst);
    @(negedge clk);
    drive_start(inst, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_start(inst, 1'b0);
  endtask

  // Called in the first cycle after the accepting edge; cyc counts cycles since start.
  task automatic wait_done(input int inst, input int pulse_at, input bit restart,
                           output int cyc, output res_t r);
    chk("busy after start", bsy(inst), 1);
    cyc = 1;
    while (dn(inst) == 0 && cyc < 3000) begin
      if (cyc == pulse_at) drive_start(inst, 1'b1);
      @(negedge clk);
      drive_start(inst, 1'b0);
      cyc++;
    end
    r.err  = (inst == 0) ? int'(err0)  : int'(err1);
    r.fev  = (inst == 0) ? int'(fev0)  : int'(fev1);
    r.fvec = (inst == 0) ? int'(fvec0) : int'(fvec1);
    r.vec  = (inst == 0) ? int'(vec0)  : int'(vec1);
`ifdef EVAL_EARLY_ABORT_EN
    r.ab   = (inst == 0) ? int'(ab0)   : int'(ab1);
`else
    r.ab   = 0;
`endif
    if (restart) drive_start(inst, 1'b1);
    @(negedge clk);
    chk("done one cycle", dn(inst), 0);
    chk("idle after done", bsy(inst), 0);
  endtask

  task automatic check_res(input string nm, input int cyc, input res_t r,
                           input int exp_cyc, input res_t e);
    chk({nm, " latency"}, cyc, exp_cyc);
    chk({nm, " err_count"}, r.err, e.err);
    chk({nm, " first_err_valid"}, r.fev, e.fev);
    chk({nm, " first_err_vec"}, r.fvec, e.fvec);
    chk({nm, " vec_out"}, r.vec, e.vec);
`ifdef EVAL_EARLY_ABORT_EN
    chk({nm, " aborted"}, r.ab, e.ab);
`endif
  endtask

  initial begin
    vec_rec_t tbl[5];
    res_t     r, e;
    int       cyc, seen;

    tbl[0] = '{mode: 0, err: 0,   fev: 0, fvec: 0};
    tbl[1] = '{mode: 1, err: 128, fev: 1, fvec: 0};
    tbl[2] = '{mode: 2, err: 2,   fev: 1, fvec: 8'h55};
    tbl[3] = '{mode: 3, err: 112, fev: 1, fvec: 8'h10};
    tbl[4] = '{mode: 4, err: 2,   fev: 1, fvec: 127};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
`ifdef EVAL_EARLY_ABORT_EN
    thr0 = 9'd0; thr1 = 9'd0;
`endif
    fill_ref();
    fill_mask(0);
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done0), 0);
    chk("reset vec_out", int'(vec0), 0);
    chk("reset err_count", int'(err0), 0);
    chk("reset first_err_valid", int'(fev0), 0);
    chk("reset first_err_vec", int'(fvec0), 0);
    rst = 1'b0;

    // Directed table on the zero-latency instance.
    for (int i = 0; i < 5; i++) begin
      fill_ref();
      fill_mask(tbl[i].mode);
      kick(0);
      wait_done(0, 0, 1'b0, cyc, r);
      e = '{err: tbl[i].err, fev: tbl[i].fev, fvec: tbl[i].fvec, vec: 127, ab: 0};
      check_res($sformatf("table%0d", i), cyc, r, 129, e);
    end

    // Random fault patterns against the model; the last one gets a start in FIN.
    for (int i = 0; i < 4; i++) begin
      fill_ref();
      fill_mask(9);
      model(0, e);
      kick(0);
      wait_done(0, 0, (i == 3), cyc, r);
      check_res($sformatf("rand%0d", i), cyc, r, 129, e);
    end
    // start was held through FIN (ignored) into IDLE (accepted).
    @(posedge clk);
    @(negedge clk);
    drive_start(0, 1'b0);
    wait_done(0, 0, 1'b0, cyc, r);
    check_res("back-to-back", cyc, r, 129, e);

    // Reset in the middle of a run.
    fill_mask(1);
    kick(0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", int'(busy0), 0);
    chk("midrst vec_out", int'(vec0), 0);
    chk("midrst err_count", int'(err0), 0);
    chk("midrst first_err_valid", int'(fev0), 0);
    chk("midrst done", int'(done0), 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1;
    end
    chk("no activity after midrst", seen, 0);
    model(0, e);
    kick(0);
    wait_done(0, 0, 1'b0, cyc, r);
    check_res("after midrst", cyc, r, 129, e);

    // Latency-2 instance: clean CUT with a start pulsed mid-run, then random faults.
    fill_ref();
    fill_mask(0);
    model(0, e);
    kick(1);
    wait_done(1, 100, 1'b0, cyc, r);
    check_res("lat2 clean", cyc, r, 385, e);
    for (int i = 0; i < 2; i++) begin
      fill_ref();
      fill_mask(9);
      model(0, e);
      kick(1);
      wait_done(1, 0, 1'b0, cyc, r);
      check_res($sformatf("lat2 rand%0d", i), cyc, r, 385, e);
    end

`ifdef EVAL_EARLY_ABORT_EN
    // Early abort: bit 1 wrong from 0x10 on, threshold 5 -> stops at 0x14.
    fill_ref();
    fill_mask(3);
    thr0 = 9'd5;
    kick(0);
    wait_done(0, 0, 1'b0, cyc, r);
    e = '{err: 5, fev: 1, fvec: 8'h10, vec: 8'h14, ab: 1};
    check_res("abort thr5", cyc, r, 8'h14 + 2, e);
    for (int i = 0; i < 2; i++) begin
      fill_ref();
      fill_mask(9);
      thr1 = 9'($urandom_range(1, 12));
      model(int'(thr1), e);
      kick(1);
      wait_done(1, 0, 1'b0, cyc, r);
      check_res($sformatf("abort lat2 rand%0d", i), cyc, r, (e.vec + 1) * 3 + 1, e);
    end
    thr0 = 9'd0;
    thr1 = 9'd0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
